ctrl_stage: RTL and testbench
=============================

Name: ctrl_stage

Overview:
Parametrised successor to the combinational control decoder. It decodes RV32I plus an optional M extension from the full instruction: opcode, funct3 and funct7. The decoded control bundle is registered into an ID/EX slot with valid/ready handshake, flush and reset. Multiply/divide ops occupy the slot for a configurable number of cycles through a busy counter, which stalls decode. The block sits between the ID stage and the EX stage of the pipeline.

Parameters:
- ENABLE_M, 1, 1 = decode M-extension ops; 0 = M encodings flagged illegal.
- MUL_CYCLES, 2, EX occupancy for MUL/MULH/MULHSU/MULHU (funct3[2]=0); must be >=1.
- DIV_CYCLES, 33, EX occupancy for DIV/DIVU/REM/REMU (funct3[2]=1); must be >=1.
- CNT_W, 6, busy counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_inst  in  32  instruction word.
- id_ready  out  1  block accepts id_inst this cycle.
- flush  in  1  kill the slot contents (branch taken or trap).
- ex_ready  in  1  EX consumes the slot this cycle.
- ex_valid  out  1  slot valid and complete.
- ex_br, ex_mem_read, ex_mem2reg, ex_mem_write, ex_regs_write, ex_br_addr_mode  out  1 each  control bits.
- ex_alu_op  out  3  ALU op class.
- ex_alu_src1, ex_alu_src2  out  2 each  ALU operand selects.
- ex_md_op  out  1  slot holds an M op; EX routes it to the MDU.
- ex_md_funct3  out  3  M op select.
- ex_illegal  out  1  opcode/funct undefined.
- mdu_busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (clk edge with rst=1): state IDLE, counter 0, every ex_* output 0, mdu_busy 0. rst overrides flush and accept.
- Combinational decode follows the existing control table.
  - alu_op: 000 load/store/LUI/AUIPC; 001 branch; 010 R-type; 011 I-arith; 100 JAL/JALR; 101 M op; 111 otherwise.
  - src1: PC for JAL/JALR/AUIPC; NULL for LUI; REG otherwise.
  - src2: IMM for load/store/AUIPC/I-arith/LUI; PC_PLUS4 for JAL/JALR; REG otherwise.
  - br_addr_mode: J_REG for JALR only; B_PC otherwise.
  - mem2reg = load; regs_write for load, R, I-arith, U, J types.
- M op: opcode Rtype with funct7=0000001. If ENABLE_M=1, alu_op=101 and md_op=1. If ENABLE_M=0, treated as illegal.
- Illegal (unknown opcode, or Rtype with funct7 not in {0000000, 0100000, 0000001}): ex_illegal=1; br, mem_read, mem_write, regs_write, mem2reg all 0; alu_op=111; the slot still passes through.
- id_ready = (state==IDLE) && (!ex_valid || ex_ready). It is combinational and does not depend on id_valid.
- Accept at edge N when id_valid && id_ready && !flush. Control fields are latched at N and held stable until the slot is consumed or flushed.
- Non-M op, or M op with cycles C=1: ex_valid=1 after edge N.
- M op with C>1:
  - State becomes BUSY with counter=C-1 at edge N; ex_valid=0 and mdu_busy=1.
  - The counter decrements each edge.
  - On the edge where the counter goes 1->0: state IDLE, ex_valid=1, mdu_busy=0.
  - Net result: ex_valid first rises after edge N+C-1.
- Consume: ex_valid && ex_ready at an edge clears ex_valid, unless a new accept happens at the same edge. Back-to-back throughput is 1 op/cycle for non-M ops.
- Backpressure: ex_valid=1 && ex_ready=0 holds all ex_* outputs and forces id_ready=0.
- ex_ready is ignored while BUSY.
- flush at an edge: ex_valid=0, state IDLE, counter 0, mdu_busy=0; no accept that cycle. Flush wins over a simultaneous accept and consume.
- mdu_busy = (state==BUSY).

Decomposition:
- Add to define.vh: ALU_OP_MD (3'b101), FUNCT7_M, FUNCT7_BASE, FUNCT7_ALT, plus existing opcode, REG/PC/NULL/IMM/PC_PLUS4 and J_REG/B_PC constants. Sub-module and top both include it.
- Sub-module ctrl_decode: pure combinational opcode/funct-to-bundle decoder, ENABLE_M parameter.
- ctrl_stage: handshake, slot register, BUSY FSM and counter.

Test Plan:
- addi x1,x0,5 (0x00500093), id_valid=1, ex_ready=1 -> after 1 edge ex_valid=1, alu_op=011, src1=REG, src2=IMM, regs_write=1, illegal=0.
- lw (0x0000A083) then sw (0x0010A023) back-to-back, ex_ready=1 -> consecutive ex_valid cycles. Load: mem_read=1, mem2reg=1. Store: mem_write=1, regs_write=0.
- div x3,x1,x2 (0x0220C1B3), DIV_CYCLES=33 -> mdu_busy=1 and id_ready=0 for 32 cycles. ex_valid rises after edge 32 with alu_op=101, md_funct3=100.
- mul (0x022081B3), MUL_CYCLES=2, flush asserted the cycle after accept -> ex_valid never rises, mdu_busy=0 next cycle, id_ready=1.
- Valid addi with ex_ready=0 for 3 cycles, new id_valid pending -> outputs stable, id_ready=0. On ex_ready=1, new op accepted the same edge.
- id_inst=0x00000000 -> ex_illegal=1, regs_write=0, alu_op=111. ENABLE_M=0 with a mul encoding -> ex_illegal=1. rst during BUSY -> all outputs 0 next edge.

Source files
------------

// File: rtl/ctrl_stage_pkg.sv
// Shared encodings for the ID/EX control stage: opcodes, funct7 values,
// ALU op classes, operand selects, the decoded control bundle and FSM states.
package ctrl_stage_pkg;

    // RV32I major opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // funct7 values legal under the R-type opcode
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_M    = 7'b0000001;

    // ALU op classes
    localparam logic [2:0] ALU_OP_MEM  = 3'b000;  // load/store/LUI/AUIPC
    localparam logic [2:0] ALU_OP_BR   = 3'b001;
    localparam logic [2:0] ALU_OP_R    = 3'b010;
    localparam logic [2:0] ALU_OP_I    = 3'b011;
    localparam logic [2:0] ALU_OP_JUMP = 3'b100;
    localparam logic [2:0] ALU_OP_MD   = 3'b101;
    localparam logic [2:0] ALU_OP_NONE = 3'b111;

    // ALU operand selects
    localparam logic [1:0] SRC1_REG      = 2'b00;
    localparam logic [1:0] SRC1_PC       = 2'b01;
    localparam logic [1:0] SRC1_NULL     = 2'b10;
    localparam logic [1:0] SRC2_REG      = 2'b00;
    localparam logic [1:0] SRC2_IMM      = 2'b01;
    localparam logic [1:0] SRC2_PC_PLUS4 = 2'b10;

    // Branch target base
    localparam logic B_PC  = 1'b0;
    localparam logic J_REG = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } stage_state_e;

    typedef struct packed {
        logic       br;
        logic       mem_read;
        logic       mem2reg;
        logic       mem_write;
        logic       regs_write;
        logic       br_addr_mode;
        logic [2:0] alu_op;
        logic [1:0] alu_src1;
        logic [1:0] alu_src2;
        logic       md_op;
        logic [2:0] md_funct3;
        logic       illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decoder: opcode/funct3/funct7 to control bundle.
// M-extension encodings decode to an MDU op only when ENABLE_M is set.
module ctrl_decode
    import ctrl_stage_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl
);

    // Table decode; every field defaults to the illegal/no-op shape first
    always_comb begin
        ctrl              = '0;
        ctrl.alu_op       = ALU_OP_NONE;
        ctrl.alu_src1     = SRC1_REG;
        ctrl.alu_src2     = SRC2_REG;
        ctrl.br_addr_mode = B_PC;
        case (opcode)
            OP_LOAD: begin
                ctrl.alu_op     = ALU_OP_MEM;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.mem_read   = 1'b1;
                ctrl.mem2reg    = 1'b1;
                ctrl.regs_write = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_op    = ALU_OP_MEM;
                ctrl.alu_src2  = SRC2_IMM;
                ctrl.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_op = ALU_OP_BR;
                ctrl.br     = 1'b1;
            end
            OP_JAL: begin
                ctrl.alu_op     = ALU_OP_JUMP;
                ctrl.alu_src1   = SRC1_PC;
                ctrl.alu_src2   = SRC2_PC_PLUS4;
                ctrl.regs_write = 1'b1;
            end
            OP_JALR: begin
                ctrl.alu_op       = ALU_OP_JUMP;
                ctrl.alu_src1     = SRC1_PC;
                ctrl.alu_src2     = SRC2_PC_PLUS4;
                ctrl.br_addr_mode = J_REG;
                ctrl.regs_write   = 1'b1;
            end
            OP_IARITH: begin
                ctrl.alu_op     = ALU_OP_I;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.regs_write = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_op     = ALU_OP_MEM;
                ctrl.alu_src1   = SRC1_NULL;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.regs_write = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.alu_op     = ALU_OP_MEM;
                ctrl.alu_src1   = SRC1_PC;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.regs_write = 1'b1;
            end
            OP_RTYPE: begin
                if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
                    ctrl.alu_op     = ALU_OP_R;
                    ctrl.regs_write = 1'b1;
                end else if (funct7 == FUNCT7_M && ENABLE_M != 0) begin
                    ctrl.alu_op     = ALU_OP_MD;
                    ctrl.md_op      = 1'b1;
                    ctrl.md_funct3  = funct3;
                    ctrl.regs_write = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_stage.sv
// ID/EX control slot: decodes the incoming instruction, registers the bundle
// behind a valid/ready handshake, and holds MUL/DIV ops in a BUSY state for
// their configured EX occupancy before presenting them to EX.
//
// Handshake: ID hands over id_inst on an edge where id_valid && id_ready;
// id_ready never looks at id_valid. EX takes the slot on an edge where
// ex_valid && ex_ready; while ex_valid && !ex_ready every ex_* output is held.
// flush beats both transfers in the same cycle.
module ctrl_stage
    import ctrl_stage_pkg::*;
#(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [31:0]  id_inst,
    output logic         id_ready,
    input  logic         flush,
    input  logic         ex_ready,
    output logic         ex_valid,
    output logic         ex_br,
    output logic         ex_mem_read,
    output logic         ex_mem2reg,
    output logic         ex_mem_write,
    output logic         ex_regs_write,
    output logic         ex_br_addr_mode,
    output logic [2:0]   ex_alu_op,
    output logic [1:0]   ex_alu_src1,
    output logic [1:0]   ex_alu_src2,
    output logic         ex_md_op,
    output logic [2:0]   ex_md_funct3,
    output logic         ex_illegal,
    output logic         mdu_busy,
    output stage_state_e dbg_state
);

    // Counter preload is cycles-1: the op becomes visible on the edge where
    // the counter steps 1 -> 0, i.e. C-1 edges after the accept edge.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    ctrl_bundle_t     dec;
    ctrl_bundle_t     slot_q;
    stage_state_e     state_q;
    stage_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] md_load;
    logic             valid_q;
    logic             valid_d;
    logic             load_slot;
    logic             accept;
    logic             multi;
    logic             unused_inst_bits;

    // Operand register fields and immediates are not needed for control
    assign unused_inst_bits = ^{id_inst[24:15], id_inst[11:7]};

    ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .opcode (id_inst[6:0]),
        .funct3 (id_inst[14:12]),
        .funct7 (id_inst[31:25]),
        .ctrl   (dec)
    );

    assign id_ready = (state_q == ST_IDLE) && (!valid_q || ex_ready);
    assign accept   = id_valid && id_ready && !flush;
    assign md_load  = dec.md_funct3[2] ? DIV_LOAD : MUL_LOAD;
    assign multi    = dec.md_op && (md_load != '0);

    // Next state: flush, then accept, then BUSY countdown, then consume
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        load_slot = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            load_slot = 1'b1;
            if (multi) begin
                state_d = ST_BUSY;
                cnt_d   = md_load;
                valid_d = 1'b0;
            end else begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                valid_d = 1'b1;
            end
        end else if (valid_q && ex_ready) begin
            valid_d = 1'b0;
        end
    end

    // State, counter and slot registers; the slot only loads on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            if (load_slot) begin
                slot_q <= dec;
            end
        end
    end

    assign ex_valid        = valid_q;
    assign ex_br           = slot_q.br;
    assign ex_mem_read     = slot_q.mem_read;
    assign ex_mem2reg      = slot_q.mem2reg;
    assign ex_mem_write    = slot_q.mem_write;
    assign ex_regs_write   = slot_q.regs_write;
    assign ex_br_addr_mode = slot_q.br_addr_mode;
    assign ex_alu_op       = slot_q.alu_op;
    assign ex_alu_src1     = slot_q.alu_src1;
    assign ex_alu_src2     = slot_q.alu_src2;
    assign ex_md_op        = slot_q.md_op;
    assign ex_md_funct3    = slot_q.md_funct3;
    assign ex_illegal      = slot_q.illegal;
    assign mdu_busy        = (state_q == ST_BUSY);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_ctrl_stage.sv
// Bench for ctrl_stage: reset, a decode table, hand-written multi-cycle
// sequences, and a randomized run against an occupancy model of the slot.
`timescale 1ns/1ps
module tb_ctrl_stage;
    import ctrl_stage_pkg::*;

    localparam int MUL_C = 2;
    localparam int DIV_C = 33;
    localparam int N_TBL = 13;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        id_valid, id_ready, flush, ex_ready, ex_valid;
    logic [31:0] id_inst;
    logic        ex_br, ex_mem_read, ex_mem2reg, ex_mem_write, ex_regs_write, ex_br_addr_mode;
    logic [2:0]  ex_alu_op, ex_md_funct3;
    logic [1:0]  ex_alu_src1, ex_alu_src2;
    logic        ex_md_op, ex_illegal, mdu_busy;
    stage_state_e dbg_state;

    logic        n_id_valid, n_id_ready, n_ex_valid;
    logic [31:0] n_id_inst;
    logic        n_br, n_mem_read, n_mem2reg, n_mem_write, n_regs_write, n_br_addr_mode;
    logic [2:0]  n_alu_op, n_md_funct3;
    logic [1:0]  n_alu_src1, n_alu_src2;
    logic        n_md_op, n_illegal, n_mdu_busy;
    stage_state_e n_dbg_state;

    ctrl_stage #(.ENABLE_M(1), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_ready(id_ready),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_br(ex_br),
        .ex_mem_read(ex_mem_read), .ex_mem2reg(ex_mem2reg), .ex_mem_write(ex_mem_write),
        .ex_regs_write(ex_regs_write), .ex_br_addr_mode(ex_br_addr_mode), .ex_alu_op(ex_alu_op),
        .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2), .ex_md_op(ex_md_op),
        .ex_md_funct3(ex_md_funct3), .ex_illegal(ex_illegal), .mdu_busy(mdu_busy),
        .dbg_state(dbg_state)
    );

    // Second instance with the M extension disabled
    ctrl_stage #(.ENABLE_M(0), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .CNT_W(6)) dut_nom (
        .clk(clk), .rst(rst), .id_valid(n_id_valid), .id_inst(n_id_inst), .id_ready(n_id_ready),
        .flush(1'b0), .ex_ready(1'b1), .ex_valid(n_ex_valid), .ex_br(n_br),
        .ex_mem_read(n_mem_read), .ex_mem2reg(n_mem2reg), .ex_mem_write(n_mem_write),
        .ex_regs_write(n_regs_write), .ex_br_addr_mode(n_br_addr_mode), .ex_alu_op(n_alu_op),
        .ex_alu_src1(n_alu_src1), .ex_alu_src2(n_alu_src2), .ex_md_op(n_md_op),
        .ex_md_funct3(n_md_funct3), .ex_illegal(n_illegal), .mdu_busy(n_mdu_busy),
        .dbg_state(n_dbg_state)
    );

    // ---------------- expected records ----------------
    typedef struct {
        logic [31:0] inst;
        logic [2:0]  alu;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic        br, mr, m2r, mw, rw, bam, md;
        logic [2:0]  mdf3;
        logic        ill;
    } vec_t;

    vec_t tbl[N_TBL];

    int n_checks = 0;
    int n_pass   = 0;

    // flags = {br, mem_read, mem2reg, mem_write, regs_write, br_addr_mode}
    function automatic vec_t v(logic [31:0] inst, logic [2:0] alu, logic [1:0] s1,
                               logic [1:0] s2, logic [5:0] flags, logic ill);
        vec_t r;
        r.inst = inst; r.alu = alu; r.s1 = s1; r.s2 = s2;
        {r.br, r.mr, r.m2r, r.mw, r.rw, r.bam} = flags;
        r.md = 1'b0; r.mdf3 = 3'b000; r.ill = ill;
        return r;
    endfunction

    function automatic logic [31:0] pack(vec_t e);
        return {14'd0, e.br, e.mr, e.m2r, e.mw, e.rw, e.bam, e.alu, e.s1, e.s2, e.md, e.mdf3, e.ill};
    endfunction

    function automatic logic [31:0] act_pack();
        return {14'd0, ex_br, ex_mem_read, ex_mem2reg, ex_mem_write, ex_regs_write,
                ex_br_addr_mode, ex_alu_op, ex_alu_src1, ex_alu_src2, ex_md_op, ex_md_funct3, ex_illegal};
    endfunction

    function automatic logic [31:0] act_pack_n();
        return {14'd0, n_br, n_mem_read, n_mem2reg, n_mem_write, n_regs_write,
                n_br_addr_mode, n_alu_op, n_alu_src1, n_alu_src2, n_md_op, n_md_funct3, n_illegal};
    endfunction

    // Reference decode straight from the control table, by instruction class
    function automatic vec_t ref_decode(logic [31:0] inst);
        vec_t r;
        logic [6:0] op;
        logic [6:0] f7;
        op = inst[6:0];
        f7 = inst[31:25];
        r = v(inst, 3'b111, SRC1_REG, SRC2_REG, 6'b000000, 1'b1);
        if (op == 7'h03)      r = v(inst, 3'b000, SRC1_REG,  SRC2_IMM,      6'b011010, 1'b0);
        else if (op == 7'h23) r = v(inst, 3'b000, SRC1_REG,  SRC2_IMM,      6'b000100, 1'b0);
        else if (op == 7'h63) r = v(inst, 3'b001, SRC1_REG,  SRC2_REG,      6'b100000, 1'b0);
        else if (op == 7'h6F) r = v(inst, 3'b100, SRC1_PC,   SRC2_PC_PLUS4, 6'b000010, 1'b0);
        else if (op == 7'h67) r = v(inst, 3'b100, SRC1_PC,   SRC2_PC_PLUS4, 6'b000011, 1'b0);
        else if (op == 7'h13) r = v(inst, 3'b011, SRC1_REG,  SRC2_IMM,      6'b000010, 1'b0);
        else if (op == 7'h37) r = v(inst, 3'b000, SRC1_NULL, SRC2_IMM,      6'b000010, 1'b0);
        else if (op == 7'h17) r = v(inst, 3'b000, SRC1_PC,   SRC2_IMM,      6'b000010, 1'b0);
        else if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20))
                              r = v(inst, 3'b010, SRC1_REG,  SRC2_REG,      6'b000010, 1'b0);
        else if (op == 7'h33 && f7 == 7'h01) begin
            r = v(inst, 3'b101, SRC1_REG, SRC2_REG, 6'b000010, 1'b0);
            r.md = 1'b1;
            r.mdf3 = inst[14:12];
        end
        return r;
    endfunction

    // ---------------- driver / scoreboard helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] pick_inst();
        int k;
        logic [31:0] w;
        logic [31:0] r;
        k = $urandom_range(0, 9);
        w = $urandom();
        case (k)
            0: r = w;
            1, 2: begin
                r = {7'h01, w[24:0]};
                r[6:0] = 7'h33;
            end
            3: begin
                r = w;
                r[6:0] = 7'h33;
            end
            default: begin
                r = tbl[$urandom_range(0, N_TBL - 1)].inst;
                r[24:15] = w[24:15];
                r[11:7]  = w[11:7];
            end
        endcase
        return r;
    endfunction

    // ---------------- test ----------------
    initial begin : main
        bit m_has;
        int m_wait;
        logic m_valid, m_ready;
        vec_t m_exp;
        vec_t e_mul_off;

        tbl[0]  = v(I_ADDI,       3'b011, SRC1_REG,  SRC2_IMM,      6'b000010, 1'b0);
        tbl[1]  = v(32'h0000A083, 3'b000, SRC1_REG,  SRC2_IMM,      6'b011010, 1'b0); // lw
        tbl[2]  = v(32'h0010A023, 3'b000, SRC1_REG,  SRC2_IMM,      6'b000100, 1'b0); // sw
        tbl[3]  = v(32'h00208463, 3'b001, SRC1_REG,  SRC2_REG,      6'b100000, 1'b0); // beq
        tbl[4]  = v(32'h008000EF, 3'b100, SRC1_PC,   SRC2_PC_PLUS4, 6'b000010, 1'b0); // jal
        tbl[5]  = v(32'h000100E7, 3'b100, SRC1_PC,   SRC2_PC_PLUS4, 6'b000011, 1'b0); // jalr
        tbl[6]  = v(32'h123450B7, 3'b000, SRC1_NULL, SRC2_IMM,      6'b000010, 1'b0); // lui
        tbl[7]  = v(32'h12345097, 3'b000, SRC1_PC,   SRC2_IMM,      6'b000010, 1'b0); // auipc
        tbl[8]  = v(I_ADD,        3'b010, SRC1_REG,  SRC2_REG,      6'b000010, 1'b0); // add
        tbl[9]  = v(32'h402081B3, 3'b010, SRC1_REG,  SRC2_REG,      6'b000010, 1'b0); // sub
        tbl[10] = v(32'h00000000, 3'b111, SRC1_REG,  SRC2_REG,      6'b000000, 1'b1);
        tbl[11] = v(32'h202081B3, 3'b111, SRC1_REG,  SRC2_REG,      6'b000000, 1'b1); // bad funct7
        tbl[12] = v(32'h0000000F, 3'b111, SRC1_REG,  SRC2_REG,      6'b000000, 1'b1); // fence
        e_mul_off = v(I_MUL,      3'b111, SRC1_REG,  SRC2_REG,      6'b000000, 1'b1);

        rst = 1'b1; id_valid = 1'b0; id_inst = '0; flush = 1'b0; ex_ready = 1'b0;
        n_id_valid = 1'b0; n_id_inst = '0;
        step();
        step();
        check("reset_fields", act_pack(), 32'd0);
        check("reset_valid_busy", {30'd0, ex_valid, mdu_busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_id_ready", {31'd0, id_ready}, 32'd1);

        // Decode table, back-to-back with EX always ready
        for (int i = 0; i < N_TBL; i++) begin
            id_valid = 1'b1; id_inst = tbl[i].inst; ex_ready = 1'b1;
            step();
            check("tbl_valid", {31'd0, ex_valid}, 32'd1);
            check("tbl_ctrl", act_pack(), pack(tbl[i]));
        end
        id_valid = 1'b0;
        step();
        check("tbl_drained", {31'd0, ex_valid}, 32'd0);

        // M disabled: a mul encoding is illegal and single-cycle
        n_id_valid = 1'b1; n_id_inst = I_MUL;
        step();
        n_id_valid = 1'b0;
        check("nom_valid_busy", {30'd0, n_ex_valid, n_mdu_busy}, 32'd2);
        check("nom_ctrl", act_pack_n(), pack(e_mul_off));

        // DIV occupies the slot for 32 cycles, then presents
        id_valid = 1'b1; id_inst = I_DIV; ex_ready = 1'b1;
        step();
        id_valid = 1'b0;
        for (int i = 0; i < DIV_C - 1; i++) begin
            #1;
            check("div_busy", {29'd0, mdu_busy, id_ready, ex_valid}, 32'd4);
            step();
        end
        check("div_done", {29'd0, mdu_busy, id_ready, ex_valid}, 32'd3);
        check("div_ctrl", act_pack(), pack(ref_decode(I_DIV)));
        check("div_alu_f3", {26'd0, ex_alu_op, ex_md_funct3}, {26'd0, 3'b101, 3'b100});
        step();
        check("div_consumed", {31'd0, ex_valid}, 32'd0);

        // MUL flushed the cycle after accept never reaches EX
        id_valid = 1'b1; id_inst = I_MUL;
        step();
        id_valid = 1'b0;
        check("mul_busy", {30'd0, mdu_busy, ex_valid}, 32'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("mul_flushed", {29'd0, mdu_busy, id_ready, ex_valid}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mul_stays_dead", {31'd0, ex_valid}, 32'd0);
        end

        // Backpressure holds the slot; release accepts the pending op same edge
        ex_ready = 1'b0; id_valid = 1'b1; id_inst = I_ADDI;
        step();
        id_inst = I_ADD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_hold", {30'd0, ex_valid, id_ready}, 32'd2);
            check("bp_ctrl", act_pack(), pack(tbl[0]));
            step();
        end
        ex_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("bp_next_valid", {31'd0, ex_valid}, 32'd1);
        check("bp_next_ctrl", act_pack(), pack(tbl[8]));

        // Flush beats a simultaneous accept and consume
        flush = 1'b1; id_inst = I_ADDI;
        step();
        flush = 1'b0; id_valid = 1'b0;
        check("flush_wins", {31'd0, ex_valid}, 32'd0);

        // Reset in the middle of a DIV
        id_valid = 1'b1; id_inst = I_DIV;
        step();
        id_valid = 1'b0;
        step();
        step();
        check("rst_pre_busy", {31'd0, mdu_busy}, 32'd1);
        rst = 1'b1;
        step();
        check("rst_busy_fields", act_pack(), 32'd0);
        check("rst_busy_flags", {29'd0, ex_valid, mdu_busy, dbg_state}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_busy_ready", {31'd0, id_ready}, 32'd1);

        // Randomized run against the slot occupancy model
        m_has = 1'b0; m_wait = 0; m_exp = tbl[0];
        for (int cyc = 0; cyc < 800; cyc++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_inst  = pick_inst();
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            m_valid = m_has && (m_wait == 0);
            m_ready = (m_wait == 0) && (!m_valid || ex_ready);
            check("rnd_handshake", {29'd0, id_ready, ex_valid, mdu_busy},
                  {29'd0, m_ready, m_valid, (m_has && m_wait > 0)});
            if (m_valid) check("rnd_ctrl", act_pack(), pack(m_exp));
            if (flush) begin
                m_has = 1'b0;
                m_wait = 0;
            end else if (id_valid && m_ready) begin
                m_has = 1'b1;
                m_exp = ref_decode(id_inst);
                m_wait = m_exp.md ? ((m_exp.mdf3[2] ? DIV_C : MUL_C) - 1) : 0;
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (m_valid && ex_ready) begin
                m_has = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
